// File: rtl/dadda_pkg.sv
// Shared types and constants for the Dadda multiply-add sequencer.
package dadda_pkg;

    localparam int OP_W  = 8;
    localparam int ACC_W = 16;
    localparam int RES_W = 17;

    localparam logic [ACC_W-1:0] ACC_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Clamp a core result to the accumulator width.
    function automatic logic [ACC_W-1:0] sat_res(input logic [RES_W-1:0] res);
        return res[RES_W-1] ? ACC_MAX : res[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/top_level.sv
// 8x8 multiply-add core: res = a*b + m.
// The partial-product array is built explicitly; the column reduction is left
// to the synthesis tool, which maps it onto a compressor tree.
module top_level
    import dadda_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic [ACC_W-1:0] m,
    output logic [RES_W-1:0] res
);

    // Sum the shifted partial-product rows together with the addend.
    always_comb begin
        logic [RES_W-1:0] sum;
        logic [RES_W-1:0] row;
        sum = RES_W'(m);
        for (int i = 0; i < OP_W; i++) begin
            row = RES_W'(a & {OP_W{b[i]}}) << i;
            sum = sum + row;
        end
        res = sum;
    end

endmodule

// File: rtl/dadda_mac_sequencer.sv
// Streaming dot-product sequencer around the multiply-add core.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_ACC   | accepting operand pairs, previous product committing to acc
// ST_DRAIN | last pair captured; its product commits, no new input
// ST_HOLD  | result presented on out_*; waits for out_ready
module dadda_mac_sequencer
    import dadda_pkg::*;
#(
    parameter int N_TERMS = 8,
    localparam int CW     = $clog2(N_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat,
    output logic [CW-1:0]    out_terms
);

    localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             sat;
    logic [CW-1:0]    count;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic             op_vld;
    logic             rdy;
    logic             vld;
    logic [RES_W-1:0] res;
    logic             accept;

    top_level u_core (
        .a   (op_a),
        .b   (op_b),
        .m   (acc),
        .res (res)
    );

    // rdy is registered; gating with rst keeps in_ready low for the whole reset pulse.
    assign in_ready  = rdy && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld;
    assign out_acc   = acc;
    assign out_sat   = sat;
    assign out_terms = count;

    // Sequencer FSM, operand capture and saturating accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_ACC;
            acc    <= '0;
            sat    <= 1'b0;
            count  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_vld <= 1'b0;
            rdy    <= 1'b0;
            vld    <= 1'b0;
        end else begin
            if (op_vld) begin
                acc <= sat_res(res);
                sat <= sat | res[RES_W-1];
            end
            case (state)
                ST_ACC: begin
                    rdy <= 1'b1;
                    if (accept) begin
                        op_a   <= in_a;
                        op_b   <= in_b;
                        op_vld <= 1'b1;
                        count  <= count + 1'b1;
                        if (count == LAST_CNT || in_last) begin
                            state <= ST_DRAIN;
                            rdy   <= 1'b0;
                        end
                    end else begin
                        op_vld <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    op_vld <= 1'b0;
                    state  <= ST_HOLD;
                end
                ST_HOLD: begin
                    // out_valid rises one cycle into HOLD, so the handshake needs both.
                    if (vld && out_ready) begin
                        acc   <= '0;
                        sat   <= 1'b0;
                        count <= '0;
                        vld   <= 1'b0;
                        rdy   <= 1'b1;
                        state <= ST_ACC;
                    end else begin
                        vld <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_ACC;
                    rdy   <= 1'b0;
                    vld   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dadda_mac_sequencer.sv
module tb_dadda_mac_sequencer;

    localparam int N_TERMS = 8;
    localparam int CW      = $clog2(N_TERMS + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_a;
    logic [7:0]    in_b;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_acc;
    logic          out_sat;
    logic [CW-1:0] out_terms;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] acc;
        logic        sat;
        int          terms;
    } exp_t;

    exp_t exp_q[$];

    int m_sum   = 0;
    int m_terms = 0;

    always #5 clk = ~clk;

    dadda_mac_sequencer #(.N_TERMS(N_TERMS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_sat   (out_sat),
        .out_terms (out_terms)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Reference model: called once per accepted pair.
    task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic last);
        exp_t e;
        m_sum   += int'(a) * int'(b);
        m_terms += 1;
        if (last || m_terms == N_TERMS) begin
            e.acc   = (m_sum > 65535) ? 16'hFFFF : m_sum[15:0];
            e.sat   = (m_sum > 65535);
            e.terms = m_terms;
            exp_q.push_back(e);
            m_sum   = 0;
            m_terms = 0;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            timeout_fail("send_wait_ready");
        end else begin
            @(posedge clk);
            model_accept(a, b, last);
            @(negedge clk);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout_fail(tag);
    endtask

    // Wait for a result, compare against the scoreboard, then consume it.
    task automatic collect(input string tag, input bit use_lit, input logic [15:0] lit);
        exp_t e;
        wait_valid({tag, "_wait"});
        if (exp_q.size() == 0) begin
            timeout_fail({tag, "_sb_empty"});
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_acc"},   32'(out_acc),   32'(e.acc));
            chk({tag, "_sat"},   32'(out_sat),   32'(e.sat));
            chk({tag, "_terms"}, 32'(out_terms), 32'(e.terms));
        end
        if (use_lit) chk({tag, "_acc_lit"}, 32'(out_acc), 32'(lit));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        logic [15:0] held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Scenario 1: reset held three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("s1_ready_in_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("s1_ready",  32'(in_ready),  32'd1);
        chk("s1_valid",  32'(out_valid), 32'd0);
        chk("s1_acc",    32'(out_acc),   32'd0);
        chk("s1_terms",  32'(out_terms), 32'd0);
        chk("s1_sat",    32'(out_sat),   32'd0);

        // Scenario 2: single term with latency check
        send(8'hFF, 8'hAA, 1'b1);
        idle();
        chk("s2_valid_k0", 32'(out_valid), 32'd0);
        chk("s2_ready_k0", 32'(in_ready),  32'd0);
        @(negedge clk);
        chk("s2_valid_k1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("s2_valid_k2", 32'(out_valid), 32'd1);
        collect("s2", 1'b1, 16'hA956);

        // Scenario 3: saturation, then a clean following result
        send(8'hFF, 8'hFF, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        idle();
        collect("s3", 1'b1, 16'hFFFF);
        chk("s3_next_acc", 32'(out_acc), 32'd0);
        chk("s3_next_sat", 32'(out_sat), 32'd0);

        // Scenario 4: full count back-to-back
        for (int i = 1; i <= 8; i++) send(8'(i), 8'd2, 1'b0);
        chk("s4_ready_drop", 32'(in_ready), 32'd0);
        idle();
        collect("s4", 1'b1, 16'h0048);

        // Scenario 4b: same stream with random bubbles
        for (int i = 1; i <= 8; i++) begin
            idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(8'(i), 8'd2, 1'b0);
        end
        idle();
        collect("s4b", 1'b1, 16'h0048);

        // Scenario 5: backpressure in HOLD
        send(8'd5, 8'd6, 1'b1);
        idle();
        wait_valid("s5_wait");
        held = out_acc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s5_hold_valid", 32'(out_valid), 32'd1);
            chk("s5_hold_acc",   32'(out_acc),   32'(held));
            chk("s5_hold_ready", 32'(in_ready),  32'd0);
        end
        collect("s5a", 1'b1, 16'd30);
        send(8'h03, 8'h04, 1'b1);
        idle();
        collect("s5b", 1'b1, 16'h000C);

        // Scenario 6: reset in the middle of a result
        send(8'd1, 8'd1, 1'b0);
        send(8'd2, 8'd1, 1'b0);
        send(8'd3, 8'd1, 1'b0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("s6_ready_in_rst", 32'(in_ready),  32'd0);
        chk("s6_valid_in_rst", 32'(out_valid), 32'd0);
        chk("s6_acc_in_rst",   32'(out_acc),   32'd0);
        rst     = 1'b0;
        m_sum   = 0;
        m_terms = 0;
        @(negedge clk);
        chk("s6_valid_after", 32'(out_valid), 32'd0);
        chk("s6_ready_after", 32'(in_ready),  32'd1);
        send(8'h02, 8'h05, 1'b1);
        idle();
        collect("s6", 1'b1, 16'h000A);
        chk("s6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
